control_word_sequencer: RTL

- Clocked command sequencer for the 8259A programming interface.
- Samples CPU write strobes and tracks the ICW1→ICW2→(ICW3)→(ICW4) initialization order.
- After initialization, decodes OCW1/2/3 writes and holds every configuration field in registers for the priority resolver, ISR/IRR and cascade logic.
- Sits between the bus interface and the interrupt core.

---
 rtl/pic8259_pkg.sv | 57 +++++
 rtl/write_strobe_detector.sv | 47 ++++
 rtl/control_word_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pic8259_pkg.sv
// Shared definitions for the 8259A programming-interface blocks: sequencer
// state encoding, command-word bit positions and OCW2 command encodings.
package pic8259_pkg;

    // Initialization/command sequencer states.
    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } cws_state_t;

    // ICW1 fields (written with A0=0, D4=1).
    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;
    localparam int ICW1_ID   = 4;

    // ICW4 fields.
    localparam int ICW4_UPM  = 0;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_SFNM = 4;

    // OCW2 fields: command in D7:5, level in D2:0.
    localparam int OCW2_CMD_LSB   = 5;
    localparam int OCW2_LEVEL_MSB = 2;

    // OCW3 fields.
    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_P    = 2;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;

    // D4:3 selects which OCW an A0=0 write in READY is.
    localparam logic [1:0] OCW_SEL_OCW2 = 2'b00;
    localparam logic [1:0] OCW_SEL_OCW3 = 2'b01;

    // OCW2 {R,SL,EOI} encodings, interpreted by the priority logic downstream.
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

    // An ICW1 is any A0=0 write with D4 set, accepted in every state.
    function automatic logic is_icw1(input logic a0, input logic [7:0] data);
        return ~a0 & data[ICW1_ID];
    endfunction

endpackage

// File: rtl/write_strobe_detector.sv
// Bus-side write strobe detector: registers the active-low CS/WR strobe,
// captures A0 and data while the strobe is active, and flags a one-cycle
// commit when the strobe ends (WR release or CS drop).
module write_strobe_detector (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       chip_select_bar,
    input  logic       write_bar,
    input  logic       a0,
    input  logic [7:0] data_in,
    output logic       commit,
    output logic       cap_a0,
    output logic [7:0] cap_data
);

    logic wr_active;
    logic wr_q;
    // A strobe already active when reset releases must be seen idle once
    // before it can produce a commit, so a write cut by reset is discarded.
    logic armed;

    assign wr_active = ~chip_select_bar & ~write_bar;
    assign commit    = wr_q & ~wr_active;

    // Strobe history and arm flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            wr_q  <= wr_active & armed;
            armed <= armed | ~wr_active;
        end
    end

    // Last address/data sampled while the strobe is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_a0   <= 1'b0;
            cap_data <= 8'h00;
        end else if (wr_active) begin
            cap_a0   <= a0;
            cap_data <= data_in;
        end
    end

endmodule

// File: rtl/control_word_sequencer.sv
// 8259A command sequencer: tracks ICW1->ICW2->(ICW3)->(ICW4) and then
// decodes OCW1/2/3, holding all configuration for the interrupt core.
// Build option: CASCADE_EN enables the ICW3/cascade path; without it the
// device is always treated as single, cascade_config is 0 and
// buffer_master is 0.
module control_word_sequencer
    import pic8259_pkg::*;
#(
    parameter logic [7:0] IMR_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_bar,
    input  logic       chip_select_bar,
    input  logic       write_bar,
    input  logic       A0,
    input  logic [7:0] data_bus_in,
    output logic       init_done,
    output logic       init_start_pulse,
    output logic       level_triggered,
    output logic       single_mode,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_config,
    output logic       auto_eoi,
    output logic       buffered_mode,
    output logic       buffer_master,
    output logic       special_fully_nested,
    output logic       x86_mode,
    output logic [7:0] interrupt_mask,
    output logic       ocw2_pulse,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_level,
    output logic       read_isr,
    output logic       poll_pulse,
    output logic       special_mask_mode,
    output cws_state_t state_dbg
);

    logic       commit;
    logic       cmd_a0;
    logic [7:0] cmd_data;

    write_strobe_detector u_strobe (
        .clk             (clk),
        .rst_n           (reset_bar),
        .chip_select_bar (chip_select_bar),
        .write_bar       (write_bar),
        .a0              (A0),
        .data_in         (data_bus_in),
        .commit          (commit),
        .cap_a0          (cmd_a0),
        .cap_data        (cmd_data)
    );

    cws_state_t state, state_next;
    logic       ic4_q;
    logic       ld_icw1, ld_icw2, ld_icw3, ld_icw4;
    logic       ld_imr, ld_ocw2, ld_ocw3;
    logic       sngl_in;     // SNGL value latched by ICW1
    logic       route_sngl;  // single-mode decision after ICW2
    logic       ms_in;       // M/S value latched by ICW4

`ifdef CASCADE_EN
    logic [7:0] cascade_q;
    assign sngl_in        = cmd_data[ICW1_SNGL];
    assign route_sngl     = single_mode;
    assign ms_in          = cmd_data[ICW4_MS];
    assign cascade_config = cascade_q;
`else
    assign sngl_in        = 1'b1;
    assign route_sngl     = 1'b1;
    assign ms_in          = 1'b0;
    assign cascade_config = 8'h00;
`endif

    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state <= ST_UNINIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and load decode for the committed command byte.
    always_comb begin
        state_next = state;
        ld_icw1    = 1'b0;
        ld_icw2    = 1'b0;
        ld_icw3    = 1'b0;
        ld_icw4    = 1'b0;
        ld_imr     = 1'b0;
        ld_ocw2    = 1'b0;
        ld_ocw3    = 1'b0;
        if (commit && is_icw1(cmd_a0, cmd_data)) begin
            ld_icw1    = 1'b1;
            state_next = ST_WAIT_ICW2;
        end else if (commit) begin
            case (state)
                ST_WAIT_ICW2: begin
                    if (cmd_a0) begin
                        ld_icw2 = 1'b1;
                        if (!route_sngl) state_next = ST_WAIT_ICW3;
                        else if (ic4_q)  state_next = ST_WAIT_ICW4;
                        else             state_next = ST_READY;
                    end
                end
                ST_WAIT_ICW3: begin
                    if (cmd_a0) begin
                        ld_icw3    = 1'b1;
                        state_next = ic4_q ? ST_WAIT_ICW4 : ST_READY;
                    end
                end
                ST_WAIT_ICW4: begin
                    if (cmd_a0) begin
                        ld_icw4    = 1'b1;
                        state_next = ST_READY;
                    end
                end
                ST_READY: begin
                    if (cmd_a0) begin
                        ld_imr = 1'b1;
                    end else if (cmd_data[4:3] == OCW_SEL_OCW2) begin
                        ld_ocw2 = 1'b1;
                    end else if (cmd_data[4:3] == OCW_SEL_OCW3) begin
                        ld_ocw3 = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Configuration registers, status and one-cycle pulses.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            ic4_q                <= 1'b0;
            init_done            <= 1'b0;
            init_start_pulse     <= 1'b0;
            level_triggered      <= 1'b0;
            single_mode          <= 1'b0;
            vector_base          <= 5'h00;
            auto_eoi             <= 1'b0;
            buffered_mode        <= 1'b0;
            buffer_master        <= 1'b0;
            special_fully_nested <= 1'b0;
            x86_mode             <= 1'b0;
            interrupt_mask       <= IMR_RESET;
            ocw2_pulse           <= 1'b0;
            ocw2_cmd             <= 3'b000;
            ocw2_level           <= 3'b000;
            read_isr             <= 1'b0;
            poll_pulse           <= 1'b0;
            special_mask_mode    <= 1'b0;
        end else begin
            init_done        <= (state_next == ST_READY);
            init_start_pulse <= ld_icw1;
            ocw2_pulse       <= ld_ocw2;
            poll_pulse       <= ld_ocw3 & cmd_data[OCW3_P];
            if (ld_icw1) begin
                level_triggered      <= cmd_data[ICW1_LTIM];
                single_mode          <= sngl_in;
                ic4_q                <= cmd_data[ICW1_IC4];
                interrupt_mask       <= 8'h00;
                special_mask_mode    <= 1'b0;
                read_isr             <= 1'b0;
                auto_eoi             <= 1'b0;
                buffered_mode        <= 1'b0;
                buffer_master        <= 1'b0;
                special_fully_nested <= 1'b0;
                x86_mode             <= 1'b0;
            end
            if (ld_icw2) vector_base <= cmd_data[7:3];
            if (ld_icw4) begin
                x86_mode             <= cmd_data[ICW4_UPM];
                auto_eoi             <= cmd_data[ICW4_AEOI];
                buffer_master        <= ms_in;
                buffered_mode        <= cmd_data[ICW4_BUF];
                special_fully_nested <= cmd_data[ICW4_SFNM];
            end
            if (ld_imr) interrupt_mask <= cmd_data;
            if (ld_ocw2) begin
                ocw2_cmd   <= cmd_data[7:OCW2_CMD_LSB];
                ocw2_level <= cmd_data[OCW2_LEVEL_MSB:0];
            end
            if (ld_ocw3) begin
                if (cmd_data[OCW3_RR])   read_isr          <= cmd_data[OCW3_RIS];
                if (cmd_data[OCW3_ESMM]) special_mask_mode <= cmd_data[OCW3_SMM];
            end
        end
    end

`ifdef CASCADE_EN
    // Cascade byte from ICW3.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            cascade_q <= 8'h00;
        end else if (ld_icw3) begin
            cascade_q <= cmd_data;
        end
    end
`endif

endmodule
